// File: rtl/column_scan_sequencer.sv
// column_scan_sequencer
//
// Steps the column select of the column multiplexer through columns 0..NINPUTS-1
// after a start pulse. At each column it waits a programmable settle time, samples
// the mux output and offers the sample downstream on a valid/ready stream.
//
// Ports:
//   CLK_I        system clock, rising edge
//   RSTN_I       asynchronous active-low reset
//   START_I      single-cycle start-of-scan request (ignored while busy)
//   ABORT_I      terminate the scan in progress (no effect when idle)
//   SETTLE_I     settle cycles per column; dwell is SETTLE_I+1 cycles
//   SELECT_O     column select to the mux
//   MUX_DATA_I   mux data output
//   PIX_DATA_O   captured column sample
//   PIX_ADR_O    column index of PIX_DATA_O
//   PIX_VALID_O  sample valid
//   PIX_READY_I  downstream ready
//   BUSY_O       high while a scan is in progress
//   DONE_O       one-cycle pulse on last-column acceptance or abort
//
// All outputs are registered.

module column_scan_sequencer #(
    parameter int unsigned DATA_WIDTH   = 1,
    parameter int unsigned ADR_WIDTH    = 8,
    parameter int unsigned NINPUTS      = 16,
    parameter int unsigned SETTLE_WIDTH = 4
) (
    input  logic                    CLK_I,
    input  logic                    RSTN_I,
    input  logic                    START_I,
    input  logic                    ABORT_I,
    input  logic [SETTLE_WIDTH-1:0] SETTLE_I,
    output logic [ADR_WIDTH-1:0]    SELECT_O,
    input  logic [DATA_WIDTH-1:0]   MUX_DATA_I,
    output logic [DATA_WIDTH-1:0]   PIX_DATA_O,
    output logic [ADR_WIDTH-1:0]    PIX_ADR_O,
    output logic                    PIX_VALID_O,
    input  logic                    PIX_READY_I,
    output logic                    BUSY_O,
    output logic                    DONE_O
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StPush
    } state_e;

    localparam logic [ADR_WIDTH-1:0] LastCol = ADR_WIDTH'(NINPUTS - 1);

    state_e                  state_q, state_d;
    logic [ADR_WIDTH-1:0]    col_q, col_d;
    logic [SETTLE_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [ADR_WIDTH-1:0]    adr_q, adr_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        adr_d   = adr_q;
        valid_d = valid_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                col_d = '0;
                if (START_I) begin
                    state_d = StSettle;
                    cnt_d   = SETTLE_I;
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - SETTLE_WIDTH'(1);
                end
            end
            StSample: begin
                data_d  = MUX_DATA_I;
                adr_d   = col_q;
                valid_d = 1'b1;
                state_d = StPush;
            end
            StPush: begin
                if (valid_q && PIX_READY_I) begin
                    valid_d = 1'b0;
                    if (col_q == LastCol) begin
                        state_d = StIdle;
                        col_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        // SETTLE_I is sampled here so each column can use a new dwell.
                        col_d   = col_q + ADR_WIDTH'(1);
                        cnt_d   = SETTLE_I;
                        state_d = StSettle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        if (ABORT_I && (state_q != StIdle)) begin
            state_d = StIdle;
            col_d   = '0;
            data_d  = data_q;
            adr_d   = adr_q;
            valid_d = 1'b0;
            done_d  = 1'b1;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK_I or negedge RSTN_I) begin
        if (!RSTN_I) begin
            state_q <= StIdle;
            col_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            adr_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            adr_q   <= adr_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SELECT_O    = col_q;
    assign PIX_DATA_O  = data_q;
    assign PIX_ADR_O   = adr_q;
    assign PIX_VALID_O = valid_q;
    assign BUSY_O      = busy_q;
    assign DONE_O      = done_q;

endmodule

// File: doc/column_scan_sequencer.md
Name: column_scan_sequencer

Overview:
Drives the column select of the decentral column multiplexer and captures the selected column data. After a start pulse it steps the select address through columns 0..NINPUTS-1. At each column it waits a programmable settle time, samples the mux output, and hands the sample downstream on a valid/ready stream. It sits directly upstream of the mux on the select path and directly downstream of it on the data path.

Parameters:
DATA_WIDTH, 1, width of one column sample (matches the mux data width)
ADR_WIDTH, 8, width of the select/column address
NINPUTS, 16, number of columns scanned per frame; requires 1 <= NINPUTS <= 2**ADR_WIDTH
SETTLE_WIDTH, 4, width of the settle-count input

Ports:
CLK_I  input  1  system clock, rising edge
RSTN_I  input  1  asynchronous active-low reset
START_I  input  1  single-cycle start-of-scan request
ABORT_I  input  1  terminate the scan in progress
SETTLE_I  input  SETTLE_WIDTH  settle cycles per column; 0 means sample on the first SETTLE cycle
SELECT_O  output  ADR_WIDTH  column select, goes to the mux select input
MUX_DATA_I  input  DATA_WIDTH  mux data output
PIX_DATA_O  output  DATA_WIDTH  captured column sample
PIX_ADR_O  output  ADR_WIDTH  column index of PIX_DATA_O
PIX_VALID_O  output  1  sample valid
PIX_READY_I  input  1  downstream ready
BUSY_O  output  1  high while not IDLE
DONE_O  output  1  one-cycle pulse when the last column is accepted or the scan is aborted

Behaviour:
- Reset (async assert, synchronous release): state IDLE. SELECT_O=0, PIX_DATA_O=0, PIX_ADR_O=0, PIX_VALID_O=0, BUSY_O=0, DONE_O=0. All outputs are registered.
- IDLE:
  - START_I=1 moves to SETTLE.
  - col=0, SELECT_O=0, settle counter loaded with SETTLE_I.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter is 0, go to SAMPLE on the next edge.
  - Minimum dwell is 1 cycle, so SETTLE_I=0 gives 1 cycle and SETTLE_I=N gives N+1 cycles.
- SAMPLE: capture MUX_DATA_I into PIX_DATA_O and col into PIX_ADR_O, set PIX_VALID_O=1, go to PUSH.
- PUSH:
  - Hold PIX_DATA_O, PIX_ADR_O and PIX_VALID_O stable while PIX_READY_I=0.
  - On the cycle PIX_VALID_O & PIX_READY_I, the transfer completes and PIX_VALID_O drops the next cycle.
  - If col==NINPUTS-1: go to IDLE, DONE_O=1 for one cycle, SELECT_O returns to 0.
  - Otherwise: col+1, SELECT_O=col+1, reload the settle counter from SETTLE_I (sampled at this edge), go to SETTLE.
- SELECT_O changes only on entry to SETTLE. It is stable from the start of SETTLE through SAMPLE.
- Latency: START_I to first PIX_VALID_O is SETTLE_I+2 cycles. With READY held high, the per-column period is SETTLE_I+3 cycles.
- START_I while BUSY_O=1 is ignored (no restart, no queueing).
- ABORT_I while BUSY_O=1, from any non-IDLE state:
  - Next state IDLE, PIX_VALID_O=0 (a pending sample is dropped), SELECT_O=0, DONE_O=1 for one cycle.
  - ABORT_I takes priority over a simultaneous handshake.
  - ABORT_I in IDLE has no effect.
- START_I and ABORT_I together in IDLE: start wins.
- Address arithmetic: col is ADR_WIDTH wide and never exceeds NINPUTS-1. There is no wrap; the last column terminates the scan.
- NINPUTS=1: a single column is scanned and DONE_O follows its acceptance.
- Reset mid-scan clears everything immediately (asynchronous). No DONE_O is issued.
- DONE_O never asserts in the same cycle as PIX_VALID_O rising.

Test Plan:
1. Basic scan: NINPUTS=16, SETTLE_I=2, READY=1, MUX_DATA_I modelled as the mux with DATA_I column k = k[0] → 16 samples with PIX_ADR_O 0..15 and PIX_DATA_O=k[0]; first valid 4 cycles after START; period 5 cycles; DONE_O 1 cycle after the column-15 handshake.
2. Backpressure: READY low for 7 cycles at column 3 → PIX_DATA_O, PIX_ADR_O=3 and VALID held stable, SELECT_O stays 3, no column skipped or duplicated.
3. SETTLE_I=0 with READY=1 → the per-column period is 3 cycles; all 16 columns delivered in order.
4. ABORT_I asserted in PUSH at column 5 with READY=1 in the same cycle → no transfer counted, VALID=0 the next cycle, DONE_O pulses once, SELECT_O=0, BUSY_O=0.
5. START_I re-pulsed at column 8 → ignored; the scan continues to 15 and exactly one DONE_O is issued.
6. RSTN_I low at column 10 mid-SETTLE → all outputs 0 asynchronously, no DONE_O; a following START_I scans from column 0.
